muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Accepts one M-extension operation at a time through a request/done handshake and computes it with a radix-2 shift-add or shift-subtract datapath.
- Drives a stall so the pipeline holds the instruction in EX until the result is ready.
- Owns the sequencing FSM, operand sign handling and all RISC-V divide corner cases.

## Interface
- DATA_WIDTH, 32: operand/result width; the iteration count equals DATA_WIDTH.
- clk  input  1  core clock; all state updates on the rising edge.
- rst_b  input  1  reset, synchronous, active-low.
- mdu_req  input  1  EX holds a valid M-extension instruction; held high until mdu_done.
- mdu_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- mdu_oprand_0  input  DATA_WIDTH  rs1 value.
- mdu_oprand_1  input  DATA_WIDTH  rs2 value.
- mdu_flush  input  1  pipeline flush; aborts any operation.
- mdu_stall  output  1  combinational: mdu_req & ~mdu_done.
- mdu_done  output  1  registered, one-cycle pulse; mdu_result is valid in this cycle.
- mdu_result  output  DATA_WIDTH  registered result, held until the next mdu_done.

## Operation
- FSM states are IDLE, CALC, FIXUP and DONE.
- **IDLE:**
  - Accept when mdu_req=1 and mdu_flush=0.
  - Latch the op and the operand magnitudes: take the absolute value of each operand treated as signed for that op. MULH and DIV/REM treat both as signed; MULHSU treats only rs1 as signed; MUL and the U variants treat both as unsigned.
  - Latch the result-sign flags and clear the iteration counter.
- **Special-case divides** go IDLE→DONE directly:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = rs1.
  - Signed overflow, DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- **CALC:** one iteration per cycle for DATA_WIDTH cycles, then FIXUP.
  - Multiply: 2*DATA_WIDTH-bit accumulator; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: restoring. Shift the {remainder, dividend} pair left, trial-subtract the divisor, and set the quotient bit when the result is non-negative.
- **FIXUP:**
  - Apply two's-complement negation per the sign flags.
  - Product sign = XOR of the operand signs.
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
  - Select the result half: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder.
  - Register mdu_result; go to DONE.
- **DONE:** mdu_done=1 for exactly one cycle, then IDLE unconditionally.
- **Back-to-back:** mdu_req high in the IDLE cycle after DONE is a new request, because the pipeline has advanced; accept it normally.
- **Inputs while busy:** mdu_op and the operands are ignored outside IDLE.
- **mdu_flush** has priority over everything in every state:
  - Next state is IDLE; no mdu_done for the aborted operation; mdu_result unchanged.
  - A flush coincident with DONE suppresses nothing already visible; the pulse in that cycle stands.
- **Reset, rst_b=0 at the clock edge, including mid-operation:**
  - State IDLE, counter 0.
  - mdu_done=0; mdu_result=0.
  - mdu_stall follows its combinational equation.
- **Arithmetic width:** all arithmetic is modulo 2^DATA_WIDTH, except the 2*DATA_WIDTH-bit product accumulator and the DATA_WIDTH+1-bit trial difference.

## Timing
- Cycle 0 is the IDLE cycle in which mdu_req is sampled.
- Normal op: CALC in cycles 1..32, FIXUP in cycle 33, DONE in cycle 34 (mdu_done=1). Latency 34 cycles.
- Special-case divide: DONE in cycle 1. Latency 1 cycle.
- mdu_stall is 1 from cycle 0 through the cycle before DONE, and 0 in the DONE cycle, so EX advances on that edge.
- Throughput: a new request is accepted at earliest the cycle after DONE.
- After a flush in cycle N, a request can be accepted in cycle N+1.

## Test plan
- MUL 7 × −3 → mdu_result 0xFFFFFFEB at cycle 34; mdu_done high exactly one cycle; mdu_stall high for cycles 0..33.
- MULH / MULHSU / MULHU of 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Divide corner cases, each with mdu_done at cycle 1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM 0x80000000 / −1 → 0.
- Interruptions:
  - mdu_flush at cycle 10 of a DIV → no mdu_done; mdu_result keeps its prior value; a new MUL 3 × 4 requested the next cycle returns 12 after 34 cycles.
  - rst_b low at cycle 20 → mdu_result 0, IDLE.
- Back-to-back: REMU 9 / 4 then DIVU 9 / 4 with mdu_req held across DONE → results 1 then 2; the second is accepted in the cycle after the first mdu_done.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/done handshake between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mdu_req;
    logic [2:0]            mdu_op;
    logic [DATA_WIDTH-1:0] mdu_oprand_0;
    logic [DATA_WIDTH-1:0] mdu_oprand_1;
    logic                  mdu_flush;
    logic                  mdu_stall;
    logic                  mdu_done;
    logic [DATA_WIDTH-1:0] mdu_result;

    modport master (
        output mdu_req, mdu_op, mdu_oprand_0, mdu_oprand_1, mdu_flush,
        input  mdu_stall, mdu_done, mdu_result
    );

    modport slave (
        input  mdu_req, mdu_op, mdu_oprand_0, mdu_oprand_1, mdu_flush,
        output mdu_stall, mdu_done, mdu_result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
//
// state | meaning
// IDLE  | waiting for a request; latches op, operand magnitudes, result sign
// CALC  | one shift-add / shift-subtract iteration per cycle, DATA_WIDTH cycles
// FIXUP | sign correction and result-half selection, result registered
// DONE  | mdu_done pulse for one cycle
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_b,
    muldiv_unit_if.slave  mdu
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t         state_q;
    logic [2:0]     op_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   b_q;
    logic           neg_q;
    logic           done_q;
    logic [W-1:0]   result_q;

    logic           signed_a, signed_b, sa, sb, neg_d;
    logic [W-1:0]   mag_a, mag_b;
    logic           special, div_zero, div_ovf;
    logic [W-1:0]   special_res;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh, diff;
    logic           q_bit;
    logic [2*W-1:0] acc_d;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   div_sel;
    logic [W-1:0]   res_fix;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    // Request decode: operand signedness, magnitudes, result sign and divide corner cases.
    always_comb begin
        signed_a = (mdu.mdu_op == 3'b001) || (mdu.mdu_op == 3'b010) ||
                   (mdu.mdu_op == 3'b100) || (mdu.mdu_op == 3'b110);
        signed_b = (mdu.mdu_op == 3'b001) || (mdu.mdu_op == 3'b100) ||
                   (mdu.mdu_op == 3'b110);
        sa       = signed_a & mdu.mdu_oprand_0[W-1];
        sb       = signed_b & mdu.mdu_oprand_1[W-1];
        mag_a    = sa ? -mdu.mdu_oprand_0 : mdu.mdu_oprand_0;
        mag_b    = sb ? -mdu.mdu_oprand_1 : mdu.mdu_oprand_1;
        // Remainder takes the dividend's sign; everything else the XOR of both.
        neg_d    = (mdu.mdu_op[2] && mdu.mdu_op[1]) ? sa : (sa ^ sb);
        div_zero = mdu.mdu_op[2] && (mdu.mdu_oprand_1 == '0);
        div_ovf  = mdu.mdu_op[2] && !mdu.mdu_op[0] &&
                   (mdu.mdu_oprand_0 == MIN_NEG) && (mdu.mdu_oprand_1 == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = mdu.mdu_op[1] ? mdu.mdu_oprand_0 : '1;
        else
            special_res = mdu.mdu_op[1] ? '0 : MIN_NEG;
    end

    // One datapath iteration, plus the sign fixup applied once iteration is complete.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Shifted remainder needs W+1 bits; the difference stays within W+1 signed bits.
        rem_sh  = acc_q[2*W-1:W-1];
        diff    = rem_sh - {1'b0, b_q};
        q_bit   = ~diff[W];
        if (op_q[2])
            acc_d = {(q_bit ? diff[W-1:0] : rem_sh[W-1:0]), acc_q[W-2:0], q_bit};
        else
            acc_d = {mul_sum, acc_q[W-1:1]};

        prod_fix = neg_q ? -acc_q : acc_q;
        div_sel  = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
        if (op_q[2])
            res_fix = neg_q ? -div_sel : div_sel;
        else if (op_q[1:0] == 2'b00)
            res_fix = prod_fix[W-1:0];
        else
            res_fix = prod_fix[2*W-1:W];
    end

    // Sequencing FSM with registered done/result; flush overrides every state.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (mdu.mdu_flush) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (mdu.mdu_req) begin
                        op_q  <= mdu.mdu_op;
                        acc_q <= {{W{1'b0}}, mag_a};
                        b_q   <= mag_b;
                        neg_q <= neg_d;
                        cnt_q <= '0;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W-1))
                        state_q <= S_FIXUP;
                end
                S_FIXUP: begin
                    result_q <= res_fix;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mdu.mdu_done   = done_q;
    assign mdu.mdu_result = result_q;
    assign mdu.mdu_stall  = mdu.mdu_req & ~done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, interruptions, random ops.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.DATA_WIDTH(W)) mdu_if ();
    muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_b(rst_b), .mdu(mdu_if));

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics with wide plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_if.mdu_op       = op;
        mdu_if.mdu_oprand_0 = a;
        mdu_if.mdu_oprand_1 = b;
        mdu_if.mdu_req      = 1'b1;
    endtask

    // Called at the negedge of cycle 0; returns at the negedge of the DONE cycle
    // (hold=1) or one cycle later with mdu_req dropped (hold=0).
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res,
                             input bit hold);
        int n;
        bit stall_ok;
        n = 0;
        stall_ok = 1'b1;
        #1;
        check({tag, "/stall_c0"}, 32'(mdu_if.mdu_stall), 32'd1);
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (mdu_if.mdu_done) break;
            if (!mdu_if.mdu_stall) stall_ok = 1'b0;
        end
        check({tag, "/latency"}, 32'(n), 32'(exp_lat));
        check({tag, "/stall_busy"}, 32'(stall_ok), 32'd1);
        check({tag, "/result"}, mdu_if.mdu_result, exp_res);
        check({tag, "/stall_done"}, 32'(mdu_if.mdu_stall), 32'd0);
        last_res = exp_res;
        if (!hold) begin
            mdu_if.mdu_req = 1'b0;
            @(negedge clk);
            check({tag, "/done_pulse"}, 32'(mdu_if.mdu_done), 32'd0);
            check({tag, "/result_hold"}, mdu_if.mdu_result, exp_res);
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        mdu_if.mdu_req = 1'b0;
        mdu_if.mdu_flush = 1'b0;
        mdu_if.mdu_op = '0;
        mdu_if.mdu_oprand_0 = '0;
        mdu_if.mdu_oprand_1 = '0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/done", 32'(mdu_if.mdu_done), 32'd0);
        check("rst/result", mdu_if.mdu_result, 32'd0);
        check("rst/stall_idle", 32'(mdu_if.mdu_stall), 32'd0);
        mdu_if.mdu_req = 1'b1;
        #1;
        check("rst/stall_req", 32'(mdu_if.mdu_stall), 32'd1);
        mdu_if.mdu_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        start(3'd0, 32'd7, -32'sd3);                 wait_done("mul", 34, 32'hFFFF_FFEB, 0);
        start(3'd1, MIN_NEG, 32'hFFFF_FFFF);          wait_done("mulh", 34, 32'h0000_0000, 0);
        start(3'd2, MIN_NEG, 32'hFFFF_FFFF);          wait_done("mulhsu", 34, 32'h8000_0000, 0);
        start(3'd3, MIN_NEG, 32'hFFFF_FFFF);          wait_done("mulhu", 34, 32'h7FFF_FFFF, 0);
        start(3'd4, -32'sd7, 32'd2);                 wait_done("div", 34, 32'hFFFF_FFFD, 0);
        start(3'd6, -32'sd7, 32'd2);                 wait_done("rem", 34, 32'hFFFF_FFFF, 0);
        start(3'd5, 32'd100, 32'd7);                 wait_done("divu", 34, 32'd14, 0);
        start(3'd7, 32'd100, 32'd7);                 wait_done("remu", 34, 32'd2, 0);
        start(3'd4, 32'd5, 32'd0);                   wait_done("div_by0", 1, 32'hFFFF_FFFF, 0);
        start(3'd7, 32'd5, 32'd0);                   wait_done("remu_by0", 1, 32'd5, 0);
        start(3'd4, MIN_NEG, 32'hFFFF_FFFF);          wait_done("div_ovf", 1, MIN_NEG, 0);
        start(3'd6, MIN_NEG, 32'hFFFF_FFFF);          wait_done("rem_ovf", 1, 32'd0, 0);

        // Flush in cycle 10 of a divide, then a multiply requested the next cycle.
        start(3'd4, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        mdu_if.mdu_flush = 1'b1;
        @(negedge clk);
        mdu_if.mdu_flush = 1'b0;
        check("flush/done", 32'(mdu_if.mdu_done), 32'd0);
        check("flush/result", mdu_if.mdu_result, last_res);
        start(3'd0, 32'd3, 32'd4);
        wait_done("flush_mul", 34, 32'd12, 0);

        // Reset mid-operation in cycle 20.
        start(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (20) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("midrst/result", mdu_if.mdu_result, 32'd0);
        check("midrst/done", 32'(mdu_if.mdu_done), 32'd0);
        mdu_if.mdu_req = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);
        last_res = '0;
        start(3'd5, 32'd100, 32'd7);
        wait_done("post_rst", 34, 32'd14, 0);

        // Back-to-back with mdu_req held across DONE.
        start(3'd7, 32'd9, 32'd4);
        wait_done("b2b_remu", 34, 32'd1, 1);
        start(3'd5, 32'd9, 32'd4);
        @(negedge clk);
        check("b2b/done_pulse", 32'(mdu_if.mdu_done), 32'd0);
        wait_done("b2b_divu", 34, 32'd2, 0);

        // Random operations, biased toward corner operands.
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: a = MIN_NEG;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            start(op, a, b);
            wait_done("rand", model_lat(op, a, b), model(op, a, b), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
